// File: rtl/ntt_pkg.sv
// ntt_pkg: shared definitions for the NTT job controller.
//   - FSM state encoding (state_e)
//   - transform mode constants (MODE_NTT / MODE_INTT)
//   - default coefficient address / data widths
//   - core_owns_port(): the states in which the core drives BRAM port A
package ntt_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  localparam logic MODE_NTT  = 1'b0;
  localparam logic MODE_INTT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_WAIT = 3'd3,
    ST_RD   = 3'd4,
    ST_HOLD = 3'd5
  } state_e;

  function automatic logic core_owns_port(input state_e s);
    return (s == ST_RUN) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/ntt_bram_port_mux.sv
// ntt_bram_port_mux: purely combinational 2:1 selector for BRAM port A.
// Ports:
//   sel_core_i                      1 = core requester owns the port
//   ctrl_addr_i/ctrl_we_i/ctrl_din_i  controller requester
//   core_addr_i/core_we_i/core_din_i  core requester
//   core_dout_o                     read data returned to the core
//   mem_addr_o/mem_we_o/mem_din_o   BRAM port A request
//   mem_dout_i                      BRAM port A read data
module ntt_bram_port_mux #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              sel_core_i,
  input  logic [ADDR_W-1:0] ctrl_addr_i,
  input  logic              ctrl_we_i,
  input  logic [DATA_W-1:0] ctrl_din_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic              core_we_i,
  input  logic [DATA_W-1:0] core_din_i,
  output logic [DATA_W-1:0] core_dout_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_din_o,
  input  logic [DATA_W-1:0] mem_dout_i
);

  always_comb begin
    if (sel_core_i) begin
      mem_addr_o = core_addr_i;
      mem_we_o   = core_we_i;
      mem_din_o  = core_din_i;
    end else begin
      mem_addr_o = ctrl_addr_i;
      mem_we_o   = ctrl_we_i;
      mem_din_o  = ctrl_din_i;
    end
  end

  // Read data goes back to the core unconditionally; it only looks at it
  // while it owns the port.
  assign core_dout_o = mem_dout_i;

endmodule

// File: rtl/ntt_job_ctrl.sv
// ntt_job_ctrl: sequences one NTT/INTT job: load N coefficients from the
// host into BRAM, hand BRAM port A to the core for the transform, then
// unload N results back to the host.
// Ports:
//   clk, rst (async, active low)
//   in_valid/in_ready/in_data/in_mode     host load stream (mode sampled with word 0)
//   out_valid/out_ready/out_data          host result stream
//   busy, err                             status (err is a sticky watchdog flag)
//   core_start/core_mode/core_done        core handshake
//   core_addr_a/core_we_a/core_din_a/core_dout_a   core side of BRAM port A
//   mem_addr_a/mem_we_a/mem_din_a/mem_dout_a       BRAM port A (1-cycle read latency)
// Build option: define NTT_CTRL_TIMEOUT_EN to enable the WAIT watchdog
// (TIMEOUT_CYC cycles); otherwise WAIT is unbounded and err is tied to 0.
//
// state | meaning
// IDLE  | ready for word 0 of a new job
// LOAD  | accepting words 1..N-1, one per cycle
// RUN   | single-cycle core_start pulse; core owns port A
// WAIT  | core transforming; waits for core_done
// RD    | issue BRAM read of result word cnt
// HOLD  | present result word cnt until out_ready
module ntt_job_ctrl
  import ntt_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              err,
  output logic              core_start,
  output logic              core_mode,
  input  logic              core_done,
  input  logic [ADDR_W-1:0] core_addr_a,
  input  logic              core_we_a,
  input  logic [DATA_W-1:0] core_din_a,
  output logic [DATA_W-1:0] core_dout_a,
  output logic [ADDR_W-1:0] mem_addr_a,
  output logic              mem_we_a,
  output logic [DATA_W-1:0] mem_din_a,
  input  logic [DATA_W-1:0] mem_dout_a
);

  localparam int              CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << ADDR_W) - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               first_q, first_d;

  logic               core_sel;
  logic               ctrl_we;
  logic [ADDR_W-1:0]  ctrl_addr;

`ifdef NTT_CTRL_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_NTT;
      data_q  <= '0;
      first_q <= 1'b0;
`ifdef NTT_CTRL_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      first_q <= first_d;
`ifdef NTT_CTRL_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
`ifdef NTT_CTRL_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif
    // BRAM data for the word read in RD arrives during the first HOLD
    // cycle; it is captured then and held for the rest of the stall.
    first_d = (state_q == ST_RD);
    data_d  = first_q ? mem_dout_a : data_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mode_d  = in_mode;
          cnt_d   = CNT_W'(1);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        state_d = ST_WAIT;
`ifdef NTT_CTRL_TIMEOUT_EN
        wd_d    = WD_LOAD;
`endif
      end
      ST_WAIT: begin
        if (core_done) begin
          cnt_d   = '0;
          state_d = ST_RD;
        end
`ifdef NTT_CTRL_TIMEOUT_EN
        else if (wd_q == '0) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q - 1'b1;
        end
`endif
      end
      ST_RD: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_RD;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready   = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    out_valid  = (state_q == ST_HOLD);
    busy       = (state_q != ST_IDLE);
    core_start = (state_q == ST_RUN);
    core_sel   = core_owns_port(state_q);
    ctrl_addr  = cnt_q[ADDR_W-1:0];
    // rst gates the write strobe so a host holding in_valid during reset
    // cannot corrupt BRAM while the flops are cleared.
    ctrl_we    = in_valid & in_ready & rst;
    out_data   = first_q ? mem_dout_a : data_q;
  end

  assign core_mode = mode_q;

`ifdef NTT_CTRL_TIMEOUT_EN
  assign err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign err = 1'b0;
`endif

  ntt_bram_port_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_port_mux (
    .sel_core_i  (core_sel),
    .ctrl_addr_i (ctrl_addr),
    .ctrl_we_i   (ctrl_we),
    .ctrl_din_i  (in_data),
    .core_addr_i (core_addr_a),
    .core_we_i   (core_we_a),
    .core_din_i  (core_din_a),
    .core_dout_o (core_dout_a),
    .mem_addr_o  (mem_addr_a),
    .mem_we_o    (mem_we_a),
    .mem_din_o   (mem_din_a),
    .mem_dout_i  (mem_dout_a)
  );

endmodule

// File: tb/tb_ntt_job_ctrl.sv
// tb_ntt_job_ctrl: self-checking bench for ntt_job_ctrl with a BRAM model
// and a core model that rewrites every word x as x+1 through port A.
module tb_ntt_job_ctrl;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_mode;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          busy, err, core_start, core_mode, core_done;
  logic [AW-1:0] core_addr_a;
  logic          core_we_a;
  logic [DW-1:0] core_din_a, core_dout_a;
  logic [AW-1:0] mem_addr_a;
  logic          mem_we_a;
  logic [DW-1:0] mem_din_a, mem_dout_a;

  logic          done_mdl, done_inj;
  int            core_delay;
  int            core_pulses;
  int            n_chk = 0;
  int            n_fail = 0;

  logic [DW-1:0] mem [0:N-1];

  always #5 clk = ~clk;

  assign core_done = done_mdl | done_inj;

  ntt_job_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err(err),
    .core_start(core_start), .core_mode(core_mode), .core_done(core_done),
    .core_addr_a(core_addr_a), .core_we_a(core_we_a), .core_din_a(core_din_a),
    .core_dout_a(core_dout_a),
    .mem_addr_a(mem_addr_a), .mem_we_a(mem_we_a), .mem_din_a(mem_din_a),
    .mem_dout_a(mem_dout_a)
  );

`ifdef NTT_CTRL_TIMEOUT_EN
  logic          t_in_ready, t_out_valid, t_busy, t_err, t_core_start, t_core_mode;
  logic          t_mem_we_a;
  logic [DW-1:0] t_out_data, t_core_dout_a, t_mem_din_a;
  logic [AW-1:0] t_mem_addr_a;

  ntt_job_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(100)) dut_tmo (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(t_in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(t_out_valid), .out_ready(out_ready), .out_data(t_out_data),
    .busy(t_busy), .err(t_err),
    .core_start(t_core_start), .core_mode(t_core_mode), .core_done(1'b0),
    .core_addr_a('0), .core_we_a(1'b0), .core_din_a('0),
    .core_dout_a(t_core_dout_a),
    .mem_addr_a(t_mem_addr_a), .mem_we_a(t_mem_we_a), .mem_din_a(t_mem_din_a),
    .mem_dout_a('0)
  );
`endif

  // BRAM port A: registered read, read-before-write.
  always @(posedge clk) begin
    if (mem_we_a) mem[mem_addr_a] <= mem_din_a;
    mem_dout_a <= mem[mem_addr_a];
  end

  // Core model: read word, write word+1, two cycles per word, then
  // optional extra delay and a one-cycle core_done. Abandons on reset.
  initial begin
    core_addr_a = '0; core_we_a = 1'b0; core_din_a = '0;
    done_mdl = 1'b0; core_pulses = 0;
    forever begin
      @(negedge clk);
      if (core_start === 1'b1 && rst === 1'b1) begin
        core_pulses++;
        for (int i = 0; i < N; i++) begin
          if (!rst) break;
          core_addr_a = AW'(i); core_we_a = 1'b0;
          @(negedge clk);
          if (!rst) break;
          core_we_a = 1'b1; core_din_a = core_dout_a + 16'd1;
          @(negedge clk);
        end
        core_we_a = 1'b0;
        if (rst) begin
          repeat (core_delay) @(negedge clk);
          if (rst) begin
            done_mdl = 1'b1;
            @(negedge clk);
            done_mdl = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          mode;
    logic [DW-1:0] base;
    int            slo;
    int            shi;
    int            scyc;
    int            hold_idx;
    bit            inj;
    int            core_dly;
    logic          exp_mode;
  } vec_t;

  vec_t vecs [5];

  // Load N words base+w; in_mode only carries the job mode on word 0.
  task automatic load_job(input logic mode, input logic [DW-1:0] base, input int slo,
                          input int shi, input int scyc, input bit inj, output int lerr);
    logic [DW-1:0] d;
    lerr = 0;
    for (int w = 0; w < N; w++) begin
      if (w >= slo && w <= shi) begin
        repeat (scyc) begin
          @(negedge clk);
          in_valid = 1'b0; done_inj = 1'b0;
          #1;
          if (mem_we_a !== 1'b0 || core_start !== 1'b0 || in_ready !== 1'b1) lerr++;
        end
      end
      @(negedge clk);
      d = base + DW'(w);
      in_valid = 1'b1; in_data = d;
      in_mode  = (w == 0) ? mode : ~mode;
      done_inj = inj && (w == 50);
      #1;
      if (mem_we_a !== 1'b1 || mem_addr_a !== AW'(w) || mem_din_a !== d ||
          in_ready !== 1'b1 || core_start !== 1'b0) lerr++;
    end
    @(negedge clk);
    in_valid = 1'b0; done_inj = 1'b0; in_mode = 1'b0;
    #1;
  endtask

  task automatic unload(input logic [DW-1:0] base, input int hold_idx,
                        output int derr, output int gerr, output int herr, output bit to);
    int n;
    logic [DW-1:0] e;
    derr = 0; gerr = 0; herr = 0; to = 1'b0;
    for (int i = 0; i < N; i++) begin
      n = 0;
      while (out_valid !== 1'b1 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (out_valid !== 1'b1) begin
        to = 1'b1;
        return;
      end
      if (i > 0 && n != 1) gerr++;
      e = base + DW'(i) + 16'd1;
      if (out_data !== e) derr++;
      if (i == hold_idx) begin
        out_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          if (out_valid !== 1'b1 || out_data !== e || mem_addr_a !== AW'(i)) herr++;
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int lerr, derr, gerr, herr, p0;
    bit to;
    p0 = core_pulses;
    core_delay = v.core_dly;
    out_ready = 1'b1;
    load_job(v.mode, v.base, v.slo, v.shi, v.scyc, v.inj, lerr);
    chk({tag, "_load_writes"}, lerr, 0);
    chk({tag, "_run_start"}, core_start, 1'b1);
    chk({tag, "_core_mode"}, core_mode, v.exp_mode);
    chk({tag, "_in_ready_run"}, in_ready, 1'b0);
    @(negedge clk); #1;
    chk({tag, "_run_one_cycle"}, {core_start, busy}, 2'b01);
    unload(v.base, v.hold_idx, derr, gerr, herr, to);
    chk({tag, "_unload_timeout"}, to, 1'b0);
    chk({tag, "_out_data"}, derr, 0);
    chk({tag, "_unload_rate"}, gerr, 0);
    if (v.hold_idx >= 0) chk({tag, "_hold_stable"}, herr, 0);
    chk({tag, "_idle_after"}, {busy, in_ready, out_valid, err}, 4'b0100);
    chk({tag, "_start_pulses"}, core_pulses - p0, 1);
  endtask

  initial begin
    int lerr;
    int n;
    int vcnt;
    vecs[0] = '{1'b0, 16'h0000, -1, -1, 0, -1, 1'b0, 0, 1'b0};
    vecs[1] = '{1'b1, 16'h1000, -1, -1, 0, 37, 1'b0, 0, 1'b1};
    vecs[2] = '{1'b0, 16'hFF80, 100, 120, 2, -1, 1'b0, 0, 1'b0};
    vecs[3] = '{1'b1, 16'h0500, -1, -1, 0, 255, 1'b1, 150, 1'b1};
    vecs[4] = '{1'b1, 16'h7A00, -1, -1, 0, 0, 1'b0, 0, 1'b1};

    rst = 1'b0; in_valid = 1'b1; in_data = 16'hABCD; in_mode = 1'b1;
    out_ready = 1'b0; done_inj = 1'b0; core_delay = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_status", {busy, err, out_valid, core_start, core_mode}, 5'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_mem_we", mem_we_a, 1'b0);
    chk("reset_mem_addr", mem_addr_a, 0);
    chk("reset_out_data", out_data, 0);
    @(negedge clk);
    in_valid = 1'b0; in_mode = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", in_ready, 1'b1);

    for (int k = 0; k < 4; k++) run_job(vecs[k], $sformatf("job%0d", k));

    // Reset while the core is working.
    out_ready = 1'b1; core_delay = 0;
    load_job(1'b0, 16'h2222, -1, -1, 0, 1'b0, lerr);
    chk("rstwait_load_writes", lerr, 0);
    repeat (20) @(negedge clk);
    #1;
    chk("rstwait_in_wait", {busy, in_ready, out_valid}, 3'b100);
    rst = 1'b0;
    #1;
    chk("rstwait_idle_now", {busy, in_ready, out_valid, core_start, core_mode}, 5'b01000);
    chk("rstwait_port", {mem_we_a, mem_addr_a}, 0);
    chk("rstwait_out_data", out_data, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstwait_ready_after", {in_ready, busy}, 2'b10);
    run_job(vecs[4], "job_after_rst");

`ifdef NTT_CTRL_TIMEOUT_EN
    // Watchdog instance never sees core_done.
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    load_job(1'b0, 16'h0000, -1, -1, 0, 1'b0, lerr);
    chk("tmo_run", t_core_start, 1'b1);
    n = 0;
    while (t_err !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
      if (n == 100) chk("tmo_before_limit", {t_busy, t_err}, 2'b10);
    end
    chk("tmo_cycle", n, 101);
    chk("tmo_idle", {t_busy, t_in_ready, t_err}, 3'b011);
    vcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (t_out_valid !== 1'b0) vcnt++;
    end
    chk("tmo_no_unload", vcnt, 0);
    chk("tmo_err_sticky", t_err, 1'b1);
`else
    n = 0; vcnt = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
